// File: rtl/fb_scanout_dma_if.sv
// fb_scanout_dma_if: SDRAM controller command/data port plus the pixel-FIFO write port
// of the framebuffer scan-out DMA. master = DMA side, slave = controller/FIFO side.
interface fb_scanout_dma_if #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int USEDW_W = 10
);
  logic [1:0]         command;
  logic [ADDR_W-1:0]  data_address;
  logic [DATA_W-1:0]  data_write;
  logic [DATA_W-1:0]  data_read;
  logic               data_read_valid;
  logic               data_write_done;
  logic [DATA_W-1:0]  fifo_data;
  logic               fifo_wrreq;
  logic [USEDW_W-1:0] fifo_wrusedw;

  modport master (
    output command, data_address, data_write, fifo_data, fifo_wrreq,
    input  data_read, data_read_valid, data_write_done, fifo_wrusedw
  );

  modport slave (
    input  command, data_address, data_write, fifo_data, fifo_wrreq,
    output data_read, data_read_valid, data_write_done, fifo_wrusedw
  );
endinterface

// File: rtl/fb_scanout_dma.sv
// fb_scanout_dma: double-buffered framebuffer read DMA, SDRAM -> pixel FIFO (MEM_CLK domain).
// Define FB_PATTERN_FILL_EN to compile in the power-up pattern fill of both buffers.
module fb_scanout_dma #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 32,
  parameter int FRAME_WORDS = 96000,
  parameter int BURST_LEN   = 8,
  parameter int BASE0       = 0,
  parameter int BASE1       = 131072,
  parameter int USEDW_W     = 10,
  parameter int FIFO_DEPTH  = 1024,
  parameter int LOW_THRESH  = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_swap,
  fb_scanout_dma_if.master bus,
  output logic             o_front_sel,
  output logic             o_swap_done,
  output logic             o_frame_wrap,
  output logic             o_first_data,
  output logic             o_init_done
);

  localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LVL_W = USEDW_W + 1;

  localparam logic [1:0]        CMD_IDLE  = 2'd0;
  localparam logic [1:0]        CMD_WRITE = 2'd1;
  localparam logic [1:0]        CMD_READ  = 2'd2;
  localparam logic [LVL_W-1:0]  LOW_LVL   = LVL_W'(LOW_THRESH);
  localparam logic [LVL_W-1:0]  HIGH_LVL  = LVL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(FRAME_WORDS - 1);
  localparam logic [OFF_W-1:0]  OFF_ZERO  = OFF_W'(0);
  localparam logic [OFF_W-1:0]  OFF_ONE   = OFF_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_B0   = ADDR_W'(BASE0);
  localparam logic [ADDR_W-1:0] ADDR_B1   = ADDR_W'(BASE1);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

  if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_frame_len_check
    $error("fb_scanout_dma: FRAME_WORDS must be a multiple of BURST_LEN");
  end

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_SCAN_IDLE = 2'd1,
    ST_READ      = 2'd2
  } state_t;

`ifdef FB_PATTERN_FILL_EN
  // Replicated low offset byte, inverted for buffer 1.
  function automatic logic [DATA_W-1:0] fill_pattern(input logic [OFF_W-1:0] off, input logic inv);
    logic [7:0]        b;
    logic [DATA_W-1:0] p;
    b = 8'(off);
    for (int i = 0; i < DATA_W; i++) begin
      p[i] = b[i[2:0]];
    end
    return inv ? ~p : p;
  endfunction
`endif

  state_t             r_state, w_state;
  logic [1:0]         r_command, w_command;
  logic [OFF_W-1:0]   r_offset, w_offset;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt;
  logic [ADDR_W-1:0]  r_data_address, w_data_address;
  logic [DATA_W-1:0]  r_data_write, w_data_write;
  logic               r_front_sel, w_front_sel;
  logic               r_swap_pending, w_swap_pending;
  logic               r_filling, w_filling;
  logic               r_first_data, w_first_data;
  logic               r_init_done, w_init_done;
  logic               r_fill_buf, w_fill_buf;
  logic               w_frame_wrap, w_swap_done;
  logic               w_beat, w_buf_sel;
  logic [LVL_W-1:0]   w_level;

  assign w_level = {1'b0, bus.fifo_wrusedw};
  assign w_beat  = (r_command == CMD_READ) && bus.data_read_valid;

  // Refill hysteresis; clearing at DEPTH-BURST_LEN also bounds a burst start against overflow.
  always_comb begin
    w_filling = r_filling;
    if (w_level >= HIGH_LVL) begin
      w_filling = 1'b0;
    end else if (w_level <= LOW_LVL) begin
      w_filling = 1'b1;
    end else begin
      w_filling = r_filling;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    w_state        = r_state;
    w_command      = r_command;
    w_offset       = r_offset;
    w_beat_cnt     = r_beat_cnt;
    w_front_sel    = r_front_sel;
    w_swap_pending = r_swap_pending | i_swap;
    w_first_data   = r_first_data;
    w_init_done    = r_init_done;
    w_data_write   = r_data_write;
    w_fill_buf     = r_fill_buf;
    w_frame_wrap   = 1'b0;
    w_swap_done    = 1'b0;
    case (r_state)
      ST_INIT: begin
`ifdef FB_PATTERN_FILL_EN
        if (r_command != CMD_WRITE) begin
          w_command    = CMD_WRITE;
          w_data_write = fill_pattern(r_offset, r_fill_buf);
        end else if (bus.data_write_done) begin
          if (r_offset == OFF_LAST) begin
            w_offset = OFF_ZERO;
            if (r_fill_buf) begin
              w_state      = ST_SCAN_IDLE;
              w_command    = CMD_IDLE;
              w_init_done  = 1'b1;
              w_fill_buf   = 1'b0;
              w_data_write = DATA_ZERO;
            end else begin
              w_fill_buf   = 1'b1;
              w_data_write = fill_pattern(OFF_ZERO, 1'b1);
            end
          end else begin
            w_offset     = r_offset + OFF_ONE;
            w_data_write = fill_pattern(r_offset + OFF_ONE, r_fill_buf);
          end
        end else begin
          w_command = CMD_WRITE;
        end
`else
        w_state     = ST_SCAN_IDLE;
        w_init_done = 1'b1;
`endif
      end
      ST_SCAN_IDLE: begin
        if (i_enable && w_filling) begin
          w_state    = ST_READ;
          w_command  = CMD_READ;
          w_beat_cnt = CNT_LAST;
        end else begin
          w_state = ST_SCAN_IDLE;
        end
      end
      ST_READ: begin
        if (w_beat) begin
          w_beat_cnt = r_beat_cnt - CNT_ONE;
          if (r_beat_cnt == CNT_ZERO) begin
            w_state      = ST_SCAN_IDLE;
            w_command    = CMD_IDLE;
            w_first_data = 1'b1;
            if (r_offset == OFF_LAST) begin
              // Frame boundary: the only place a buffer swap may commit.
              w_offset     = OFF_ZERO;
              w_frame_wrap = 1'b1;
              if (r_swap_pending || i_swap) begin
                w_front_sel    = ~r_front_sel;
                w_swap_done    = 1'b1;
                w_swap_pending = 1'b0;
              end else begin
                w_front_sel = r_front_sel;
              end
            end else begin
              w_offset = r_offset + OFF_ONE;
            end
          end else begin
            w_offset = r_offset + OFF_ONE;
          end
        end else begin
          w_state = ST_READ;
        end
      end
      default: begin
        w_state   = ST_INIT;
        w_command = CMD_IDLE;
      end
    endcase
  end

  assign w_buf_sel      = (w_state == ST_INIT) ? w_fill_buf : w_front_sel;
  assign w_data_address = (w_buf_sel ? ADDR_B1 : ADDR_B0) + ADDR_W'(w_offset);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_command      <= CMD_IDLE;
      r_offset       <= OFF_ZERO;
      r_beat_cnt     <= CNT_ZERO;
      r_data_address <= ADDR_B0;
      r_data_write   <= DATA_ZERO;
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_filling      <= 1'b0;
      r_first_data   <= 1'b0;
      r_init_done    <= 1'b0;
      r_fill_buf     <= 1'b0;
    end else begin
      r_command      <= w_command;
      r_offset       <= w_offset;
      r_beat_cnt     <= w_beat_cnt;
      r_data_address <= w_data_address;
      r_data_write   <= w_data_write;
      r_front_sel    <= w_front_sel;
      r_swap_pending <= w_swap_pending;
      r_filling      <= w_filling;
      r_first_data   <= w_first_data;
      r_init_done    <= w_init_done;
      r_fill_buf     <= w_fill_buf;
    end
  end

  assign bus.command      = r_command;
  assign bus.data_address = r_data_address;
  assign bus.data_write   = r_data_write;
  assign bus.fifo_data    = bus.data_read;
  assign bus.fifo_wrreq   = w_beat;
  assign o_front_sel      = r_front_sel;
  assign o_swap_done      = w_swap_done;
  assign o_frame_wrap     = w_frame_wrap;
  assign o_first_data     = r_first_data;
  assign o_init_done      = r_init_done;

endmodule

// File: tb/tb_fb_scanout_dma.sv
// tb_fb_scanout_dma: directed bench for fb_scanout_dma with a small controller/FIFO model
// (FRAME_WORDS=16, BURST_LEN=8 so frame wrap and buffer swap are reached quickly).
module tb_fb_scanout_dma;
  localparam int FW = 16;
  localparam int BL = 8;
  localparam int B1 = 131072;

  logic clk = 1'b0;
  logic rst_n;
  logic i_enable, i_swap;
  logic o_front_sel, o_swap_done, o_frame_wrap, o_first_data, o_init_done;
  logic ctl_gap, gap_tgl, usedw_auto;
  logic [9:0] usedw_force;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fb_scanout_dma_if #(.ADDR_W(22), .DATA_W(32), .USEDW_W(10)) bus ();

  fb_scanout_dma #(.FRAME_WORDS(FW), .BURST_LEN(BL), .BASE1(B1)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_swap(i_swap), .bus(bus),
    .o_front_sel(o_front_sel), .o_swap_done(o_swap_done), .o_frame_wrap(o_frame_wrap),
    .o_first_data(o_first_data), .o_init_done(o_init_done)
  );

  // Controller model: streams beats while READ is seen, acks single writes every other cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_read_valid <= 1'b0;
      bus.data_read       <= 32'd0;
      bus.data_write_done <= 1'b0;
      gap_tgl             <= 1'b0;
    end else begin
      gap_tgl             <= ~gap_tgl;
      bus.data_read_valid <= (bus.command == 2'd2) && !(ctl_gap && gap_tgl);
      if (bus.fifo_wrreq) bus.data_read <= bus.data_read + 32'd1;
      bus.data_write_done <= (bus.command == 2'd1) && !bus.data_write_done;
    end
  end

  // FIFO level model: counts writes (never drained) or holds a forced level.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.fifo_wrusedw <= usedw_auto ? 10'd0 : usedw_force;
    else if (usedw_auto) bus.fifo_wrusedw <= bus.fifo_wrusedw + {9'd0, bus.fifo_wrreq};
    else bus.fifo_wrusedw <= usedw_force;
  end

  task automatic do_reset();
    rst_n = 1'b0; i_enable = 1'b0; i_swap = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 400 && o_init_done !== 1'b1; k++) @(negedge clk);
    tests++;
    if (o_init_done !== 1'b1) begin fails++; $display("FAIL init_timeout: got %b want 1", o_init_done); end
  endtask

  task automatic test_reset();
    usedw_auto = 1'b1; ctl_gap = 1'b0;
    rst_n = 1'b0; i_enable = 1'b0; i_swap = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.command, bus.data_address, bus.data_write, o_front_sel, o_swap_done, o_frame_wrap,
         o_first_data, o_init_done} !== {2'd0, 22'd0, 32'd0, 5'b00000}) begin
      fails++;
      $display("FAIL reset_state: got cmd=%0d addr=%0h wd=%0h flags=%b want all zero", bus.command,
               bus.data_address, bus.data_write, {o_front_sel, o_swap_done, o_frame_wrap, o_first_data, o_init_done});
    end
    rst_n = 1'b1;
    @(negedge clk);
`ifdef FB_PATTERN_FILL_EN
    tests++;
    if ({o_init_done, bus.command} !== {1'b0, 2'd1}) begin
      fails++; $display("FAIL fill_start: got init=%b cmd=%0d want init=0 cmd=1", o_init_done, bus.command);
    end
`else
    tests++;
    if ({o_init_done, bus.command} !== {1'b1, 2'd0}) begin
      fails++; $display("FAIL init_one_cycle: got init=%b cmd=%0d want init=1 cmd=0", o_init_done, bus.command);
    end
`endif
  endtask

`ifdef FB_PATTERN_FILL_EN
  task automatic test_pattern_fill();
    int nw = 0;
    logic [31:0] exp_d;
    logic [7:0] b;
    usedw_auto = 1'b1; ctl_gap = 1'b0;
    rst_n = 1'b0; i_enable = 1'b0; i_swap = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 400 && o_init_done !== 1'b1; k++) begin
      @(negedge clk);
      if (bus.command == 2'd1 && bus.data_write_done) begin
        b = 8'(nw % FW);
        exp_d = (nw < FW) ? {4{b}} : ~{4{b}};
        tests++;
        if ({bus.data_address, bus.data_write} !== {22'((nw < FW ? 0 : B1) + nw % FW), exp_d}) begin
          fails++; $display("FAIL fill_word %0d: got %0h/%0h want %0h", nw, bus.data_address, bus.data_write, exp_d);
        end
        if (nw == 5) begin
          tests++;
          if (bus.data_write !== 32'h05050505) begin fails++; $display("FAIL fill_b0w5: got %0h want 05050505", bus.data_write); end
        end
        if (nw == 21) begin
          tests++;
          if (bus.data_write !== 32'hFAFAFAFA) begin fails++; $display("FAIL fill_b1w5: got %0h want FAFAFAFA", bus.data_write); end
        end
        nw++;
      end
    end
    tests++;
    if ({nw, o_init_done, bus.command} !== {32'd32, 1'b1, 2'd0}) begin
      fails++; $display("FAIL fill_end: got writes=%0d init=%b cmd=%0d want 32/1/0", nw, o_init_done, bus.command);
    end
  endtask
`endif

  task automatic test_burst_fill();
    int beats = 0, wraps = 0, wr_cmd = 0, extra = 0;
    usedw_auto = 1'b1; ctl_gap = 1'b0;
    do_reset();
    i_enable = 1'b1;
    for (int c = 0; c < 2000 && beats < 1016; c++) begin
      @(negedge clk);
      if (bus.command == 2'd1) wr_cmd++;
      if (bus.fifo_wrreq) begin
        tests++;
        if (bus.data_address !== 22'(beats % FW)) begin
          fails++; $display("FAIL t1_addr beat %0d: got %0d want %0d", beats, bus.data_address, beats % FW);
        end
        if (o_frame_wrap) wraps++;
        beats++;
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.fifo_wrreq || bus.command != 2'd0) extra++;
    end
    tests++;
    if (beats !== 1016) begin fails++; $display("FAIL t1_beats: got %0d want 1016", beats); end
    tests++;
    if ({extra, bus.fifo_wrusedw} !== {32'd0, 10'd1016}) begin
      fails++; $display("FAIL t1_stop: got extra=%0d usedw=%0d want 0/1016", extra, bus.fifo_wrusedw);
    end
    tests++;
    if (wraps !== 63) begin fails++; $display("FAIL t1_wraps: got %0d want 63", wraps); end
    tests++;
    if (o_first_data !== 1'b1) begin fails++; $display("FAIL t1_first_data: got %b want 1", o_first_data); end
`ifndef FB_PATTERN_FILL_EN
    tests++;
    if ({wr_cmd, bus.data_write} !== {32'd0, 32'd0}) begin
      fails++; $display("FAIL t1_no_write: got wrcmd=%0d wd=%0h want 0/0", wr_cmd, bus.data_write);
    end
`endif
  endtask

  task automatic test_hysteresis();
    int busy = 0, starts = 0;
    logic seen = 1'b0;
    logic [1:0] prev = 2'd0;
    usedw_auto = 1'b0; usedw_force = 10'd300; ctl_gap = 1'b0;
    do_reset();
    i_enable = 1'b1;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (bus.command != 2'd0) busy++; end
    tests++;
    if (busy !== 0) begin fails++; $display("FAIL t2_no_burst_300: got %0d busy cycles want 0", busy); end
    usedw_force = 10'd256;
    for (int c = 0; c < 2 && !seen; c++) begin @(negedge clk); seen = (bus.command == 2'd2); end
    tests++;
    if (seen !== 1'b1) begin fails++; $display("FAIL t2_start_256: got cmd=%0d want 2", bus.command); end
    usedw_force = 10'd600;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (prev == 2'd0 && bus.command == 2'd2) starts++;
      prev = bus.command;
    end
    tests++;
    if ((starts >= 4) !== 1'b1) begin fails++; $display("FAIL t2_hold_600: got %0d starts want >=4", starts); end
    usedw_force = 10'd1016;
    repeat (15) @(negedge clk);
    busy = 0;
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (bus.command != 2'd0) busy++; end
    tests++;
    if (busy !== 0) begin fails++; $display("FAIL t2_stop_1016: got %0d busy cycles want 0", busy); end
    usedw_force = 10'd300;
    busy = 0;
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (bus.command != 2'd0) busy++; end
    tests++;
    if (busy !== 0) begin fails++; $display("FAIL t2_cleared_300: got %0d busy cycles want 0", busy); end
  endtask

  task automatic test_frame_wrap();
    int n = 0, stray = 0;
    usedw_auto = 1'b1; ctl_gap = 1'b1;
    do_reset();
    i_enable = 1'b1;
    for (int c = 0; c < 400 && n < 24; c++) begin
      @(negedge clk);
      if (bus.fifo_wrreq) begin
        tests++;
        if ({bus.data_address, o_frame_wrap, bus.fifo_data} !== {22'(n % FW), (n % FW) == 15, 32'(n)}) begin
          fails++; $display("FAIL t3_beat %0d: got addr=%0d wrap=%b data=%0d want %0d/%b/%0d", n,
                            bus.data_address, o_frame_wrap, bus.fifo_data, n % FW, (n % FW) == 15, n);
        end
        n++;
      end else if (o_frame_wrap) begin
        stray++;
      end
    end
    tests++;
    if ({n, stray} !== {32'd24, 32'd0}) begin fails++; $display("FAIL t3_count: got beats=%0d stray=%0d want 24/0", n, stray); end
    ctl_gap = 1'b0;
  endtask

  task automatic test_swap();
    int n = 0;
    logic ef;
    usedw_auto = 1'b1; ctl_gap = 1'b0;
    do_reset();
    i_enable = 1'b1;
    for (int c = 0; c < 800 && n < 64; c++) begin
      @(negedge clk);
      i_swap = 1'b0;
      if (bus.fifo_wrreq) begin
        ef = (n >= 16 && n <= 47);
        tests++;
        if ({o_front_sel, bus.data_address, o_swap_done} !== {ef, 22'((ef ? B1 : 0) + n % FW), (n == 15 || n == 47)}) begin
          fails++; $display("FAIL t4_beat %0d: got front=%b addr=%0h done=%b want front=%b done=%b", n,
                            o_front_sel, bus.data_address, o_swap_done, ef, (n == 15 || n == 47));
        end
        if (n == 4 || n == 9 || n == 46) i_swap = 1'b1;
        n++;
      end
    end
    i_swap = 1'b0;
    tests++;
    if (n !== 64) begin fails++; $display("FAIL t4_count: got %0d beats want 64", n); end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    logic hit = 1'b0;
    usedw_auto = 1'b1; ctl_gap = 1'b0;
    do_reset();
    i_enable = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (bus.fifo_wrreq) begin
        if (n == 11) hit = 1'b1;
        n++;
      end
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({hit, bus.command, bus.data_address, bus.fifo_wrreq, o_first_data} !== {1'b1, 2'd0, 22'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL t5_async_reset: got hit=%b cmd=%0d addr=%0d wrreq=%b first=%b want 1/0/0/0/0",
                        hit, bus.command, bus.data_address, bus.fifo_wrreq, o_first_data);
    end
    do_reset();
    i_enable = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      @(negedge clk);
      if (bus.fifo_wrreq) begin
        tests++;
        if (bus.data_address !== 22'(n)) begin fails++; $display("FAIL t5_restart beat %0d: got %0d want %0d", n, bus.data_address, n); end
        n++;
      end
    end
    @(negedge clk);
    tests++;
    if ({n, o_first_data} !== {32'd8, 1'b1}) begin fails++; $display("FAIL t5_restart_end: got %0d/%b want 8/1", n, o_first_data); end
  endtask

  initial begin
    rst_n = 1'b0; i_enable = 1'b0; i_swap = 1'b0;
    usedw_auto = 1'b1; usedw_force = 10'd0; ctl_gap = 1'b0;
    test_reset();
`ifdef FB_PATTERN_FILL_EN
    test_pattern_fill();
`endif
    test_burst_fill();
    test_hysteresis();
    test_frame_wrap();
    test_swap();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
